// File: rtl/router_csr_pkg.sv
// rtl/router_csr_pkg.sv - shared types and constants for the router CSR arbiter
package router_csr_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_RESP  = 2'd2
    } arb_state_t;

    // Read data returned with a timed-out transaction.
    localparam int unsigned RSP_ERR_RDATA = '0;

endpackage

// File: rtl/router_rr_pick.sv
// rtl/router_rr_pick.sv - combinational rotate-priority picker
//
// Scans req_i starting at ptr_i, wrapping past N_REQ-1 back to 0, and
// returns the first asserted request.
//   req_i   [N_REQ]  request vector
//   ptr_i   [PW]     index with highest priority this cycle
//   grant_o [N_REQ]  one-hot grant (all zero when no request)
//   idx_o   [PW]     binary index of the granted requester
//   valid_o          at least one request present
module router_rr_pick #(
    parameter int N_REQ = 4,
    parameter int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PW-1:0]    ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [PW-1:0]    idx_o,
    output logic             valid_o
);

    int k;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        k       = 0;
        for (int i = 0; i < N_REQ; i++) begin
            // Wrap explicitly so non-power-of-two N_REQ works too.
            k = int'(ptr_i) + i;
            if (k >= N_REQ) begin
                k = k - N_REQ;
            end
            if (!valid_o && req_i[k]) begin
                valid_o    = 1'b1;
                idx_o      = PW'(k);
                grant_o[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/router_csr_arbiter.sv
// rtl/router_csr_arbiter.sv - round-robin arbiter sharing the router CSR slave port
//
// One CSR transaction in flight; every accepted request gets one response.
//   i_hclk, i_hreset_n          clock, asynchronous active-low reset
//   i_req_valid/write/addr/wdata per-requester request (addr/wdata flattened)
//   o_req_ready                 one-hot accept pulse, IDLE only
//   o_rsp_valid/rdata/error     one-hot response valid, shared data/error
//   i_rsp_ready                 per-requester response accept
//   o_csr_write/read/addr/wdata CSR slave strobes and fields
//   i_csr_rdata/error/ready     CSR slave completion
module router_csr_arbiter
    import router_csr_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int AWIDTH      = 32,
    parameter int DWIDTH      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                    i_hclk,
    input  logic                    i_hreset_n,
    input  logic [N_REQ-1:0]        i_req_valid,
    input  logic [N_REQ-1:0]        i_req_write,
    input  logic [N_REQ*AWIDTH-1:0] i_req_addr,
    input  logic [N_REQ*DWIDTH-1:0] i_req_wdata,
    output logic [N_REQ-1:0]        o_req_ready,
    output logic [N_REQ-1:0]        o_rsp_valid,
    output logic [DWIDTH-1:0]       o_rsp_rdata,
    output logic                    o_rsp_error,
    input  logic [N_REQ-1:0]        i_rsp_ready,
    output logic                    o_csr_write,
    output logic                    o_csr_read,
    output logic [AWIDTH-1:0]       o_csr_addr,
    output logic [DWIDTH-1:0]       o_csr_wdata,
    input  logic [DWIDTH-1:0]       i_csr_rdata,
    input  logic                    i_csr_error,
    input  logic                    i_csr_ready
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    // Keep the counter at least one bit wide when the timeout is disabled.
    localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

    arb_state_t        state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     idx_q, idx_d;
    logic              write_q, write_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic [DWIDTH-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [N_REQ-1:0]  pick_grant;
    logic [PW-1:0]     pick_idx;
    logic              pick_valid;

    router_rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_pick (
        .req_i   (i_req_valid),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        o_req_ready = '0;
        o_rsp_valid = '0;
        o_csr_read  = 1'b0;
        o_csr_write = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    // Accept is combinational; gate it so nothing is
                    // acknowledged while reset is held.
                    o_req_ready = i_hreset_n ? pick_grant : '0;
                    idx_d       = pick_idx;
                    write_d     = i_req_write[pick_idx];
                    addr_d      = i_req_addr[int'(pick_idx)*AWIDTH +: AWIDTH];
                    wdata_d     = i_req_wdata[int'(pick_idx)*DWIDTH +: DWIDTH];
                    cnt_d       = '0;
                    state_d     = ARB_ISSUE;
                end
            end

            ARB_ISSUE: begin
                o_csr_write = write_q;
                o_csr_read  = !write_q;
                // Ready is checked first so it wins in the timeout cycle.
                if (i_csr_ready) begin
                    rdata_d = write_q ? '0 : i_csr_rdata;
                    err_d   = i_csr_error;
                    state_d = ARB_RESP;
                end else if ((TIMEOUT_CYC != 0) && (cnt_q == TO_LAST)) begin
                    rdata_d = DWIDTH'(RSP_ERR_RDATA);
                    err_d   = 1'b1;
                    state_d = ARB_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ARB_RESP: begin
                o_rsp_valid[idx_q] = 1'b1;
                if (i_rsp_ready[idx_q]) begin
                    ptr_d   = (idx_q == PW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
                    state_d = ARB_IDLE;
                end
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_hclk or negedge i_hreset_n) begin
        if (!i_hreset_n) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_csr_addr  = addr_q;
    assign o_csr_wdata = wdata_q;
    assign o_rsp_rdata = rdata_q;
    assign o_rsp_error = err_q;

endmodule
